ctrl_seq: RTL and testbench

//  Parametrised micro-sequencer for the bus CPU. Owns an internal 8-beat counter (T0..T7) instead of external

---
 rtl/ctrl_seq.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_ctrl_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: 8-beat micro-sequencer for the bus CPU. It decodes IR at T2/T3 and drives
// registered one-hot register-file and bus enables, with RAM wait states and a sticky HALT/fault.
module ctrl_seq #(
  parameter int DW     = 16,
  parameter int NREG   = 4,
  parameter int SP_IDX = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic [DW-1:0]   cmd_i,
  input  logic [DW-1:0]   acc_i,
  input  logic            mem_rdy_i,
  output logic [2:0]      beat_o,
  output logic [NREG-1:0] idr_o,
  output logic [NREG-1:0] edr_o,
  output logic            iir_o,
  output logic            eir_o,
  output logic            imar_o,
  output logic            emar_o,
  output logic            iaddr_o,
  output logic            iram_o,
  output logic            eram_o,
  output logic            ialu_o,
  output logic            ealu_o,
  output logic            ipc_o,
  output logic            epc_o,
  output logic            sp_inc_o,
  output logic            sp_dec_o,
  output logic            halt_o,
  output logic            illegal_o
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LD   = 5'd1;
  localparam logic [4:0] OP_LN   = 5'd2;
  localparam logic [4:0] OP_CP   = 5'd3;
  localparam logic [4:0] OP_ST   = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_ADD  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_JZ   = 5'd8;
  localparam logic [4:0] OP_JB   = 5'd9;
  localparam logic [4:0] OP_JMP  = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_OR   = 5'd12;
  localparam logic [4:0] OP_AND  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_NOT  = 5'd15;
  localparam logic [4:0] OP_PUSH = 5'd16;
  localparam logic [4:0] OP_POP  = 5'd17;
  localparam logic [4:0] OP_HALT = 5'd18;

  // Sequencer state
  logic [2:0]      beat_q, beat_d;
  logic [4:0]      op_q, op_d;
  logic [2:0]      dst_q, dst_d;
  logic [2:0]      src_q, src_d;
  logic            taken_q, taken_d;
  logic            halt_q, halt_d;
  logic            illegal_q, illegal_d;

  // Registered enables
  logic [NREG-1:0] idr_q, idr_d;
  logic [NREG-1:0] edr_q, edr_d;
  logic            iir_q, iir_d;
  logic            eir_q, eir_d;
  logic            imar_q, imar_d;
  logic            emar_q, emar_d;
  logic            iaddr_q, iaddr_d;
  logic            iram_q, iram_d;
  logic            eram_q, eram_d;
  logic            ialu_q, ialu_d;
  logic            ealu_q, ealu_d;
  logic            ipc_q, ipc_d;
  logic            epc_q, epc_d;
  logic            sp_inc_q, sp_inc_d;
  logic            sp_dec_q, sp_dec_d;

  // Decode of the captured instruction
  logic [NREG-1:0] dst_oh, src_oh, sp_oh;
  logic            is_alu, is_jump, jump_taken;
  logic            dst_reg_ok, src_reg_ok, alu_dst_ok;
  logic            field_bad, op_bad, fault, stop_op;
  logic            stall, advance;
  logic            unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_i[DW-6:3];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_onehot
      assign dst_oh[gi] = (dst_q == 3'(gi + 1));
      assign src_oh[gi] = (src_q == 3'(gi + 1));
      assign sp_oh[gi]  = (gi + 1 == SP_IDX);
    end
  endgenerate

  assign is_alu = (op_q == OP_SHL) || (op_q == OP_ADD) || (op_q == OP_SUB) ||
                  (op_q == OP_XOR) || (op_q == OP_OR)  || (op_q == OP_AND) ||
                  (op_q == OP_SHR) || (op_q == OP_NOT);
  assign is_jump = (op_q == OP_JZ) || (op_q == OP_JB) || (op_q == OP_JMP);
  assign jump_taken = (op_q == OP_JMP) ||
                      ((op_q == OP_JZ) && (acc_i == '0)) ||
                      ((op_q == OP_JB) && acc_i[DW-1]);

  assign dst_reg_ok = (dst_q != 3'd0) && (int'(dst_q) <= NREG);
  assign src_reg_ok = (src_q != 3'd0) && (int'(src_q) <= NREG);
  assign alu_dst_ok = (int'(dst_q) <= NREG);

  // CP onto itself would raise idr and edr of one register together, so it is a fault too.
  always_comb begin
    field_bad = 1'b0;
    case (op_q)
      OP_NOP, OP_HALT, OP_JZ, OP_JB, OP_JMP: field_bad = 1'b0;
      OP_LD, OP_LN, OP_ST, OP_PUSH, OP_POP:  field_bad = !dst_reg_ok;
      OP_CP:   field_bad = !dst_reg_ok || !src_reg_ok || (dst_q == src_q);
      default: field_bad = is_alu && !alu_dst_ok;
    endcase
  end

  assign op_bad  = (op_q > OP_HALT);
  assign fault   = op_bad || field_bad;
  assign stop_op = fault || (op_q == OP_HALT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q    <= 3'd0;
      op_q      <= 5'd0;
      dst_q     <= 3'd0;
      src_q     <= 3'd0;
      taken_q   <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      idr_q     <= '0;
      edr_q     <= '0;
      iir_q     <= 1'b0;
      eir_q     <= 1'b0;
      imar_q    <= 1'b0;
      emar_q    <= 1'b0;
      iaddr_q   <= 1'b0;
      iram_q    <= 1'b0;
      eram_q    <= 1'b0;
      ialu_q    <= 1'b0;
      ealu_q    <= 1'b0;
      ipc_q     <= 1'b0;
      epc_q     <= 1'b0;
      sp_inc_q  <= 1'b0;
      sp_dec_q  <= 1'b0;
    end else begin
      beat_q    <= beat_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      taken_q   <= taken_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      idr_q     <= idr_d;
      edr_q     <= edr_d;
      iir_q     <= iir_d;
      eir_q     <= eir_d;
      imar_q    <= imar_d;
      emar_q    <= emar_d;
      iaddr_q   <= iaddr_d;
      iram_q    <= iram_d;
      eram_q    <= eram_d;
      ialu_q    <= ialu_d;
      ealu_q    <= ealu_d;
      ipc_q     <= ipc_d;
      epc_q     <= epc_d;
      sp_inc_q  <= sp_inc_d;
      sp_dec_q  <= sp_dec_d;
    end
  end

  // Next-state logic: a RAM beat waiting on mem_rdy freezes the whole sequencer.
  assign stall   = (iram_q || eram_q) && !mem_rdy_i;
  assign advance = !halt_q && !stall && !((beat_q == 3'd0) && !run_i);

  always_comb begin
    beat_d    = beat_q;
    op_d      = op_q;
    dst_d     = dst_q;
    src_d     = src_q;
    taken_d   = taken_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    if (advance) begin
      beat_d = beat_q + 3'd1;
      if (beat_q == 3'd1) begin
        op_d  = cmd_i[DW-1:DW-5];
        dst_d = cmd_i[10:8];
        src_d = cmd_i[2:0];
      end
      if (beat_q == 3'd2) begin
        taken_d   = jump_taken;
        halt_d    = stop_op;
        illegal_d = fault;
      end
    end
  end

  // Output logic: enables for the beat being entered; all hold while not advancing.
  always_comb begin
    idr_d    = idr_q;
    edr_d    = edr_q;
    iir_d    = iir_q;
    eir_d    = eir_q;
    imar_d   = imar_q;
    emar_d   = emar_q;
    iaddr_d  = iaddr_q;
    iram_d   = iram_q;
    eram_d   = eram_q;
    ialu_d   = ialu_q;
    ealu_d   = ealu_q;
    ipc_d    = ipc_q;
    epc_d    = epc_q;
    sp_inc_d = sp_inc_q;
    sp_dec_d = sp_dec_q;
    if (advance) begin
      idr_d    = '0;
      edr_d    = '0;
      iir_d    = 1'b0;
      eir_d    = 1'b0;
      imar_d   = 1'b0;
      emar_d   = 1'b0;
      iaddr_d  = 1'b0;
      iram_d   = 1'b0;
      eram_d   = 1'b0;
      ialu_d   = 1'b0;
      ealu_d   = 1'b0;
      ipc_d    = 1'b0;
      epc_d    = 1'b0;
      sp_inc_d = 1'b0;
      sp_dec_d = 1'b0;
      case (beat_d)
        3'd1: iir_d = 1'b1;
        3'd2: begin
          eir_d  = 1'b1;
          imar_d = 1'b1;
        end
        3'd3: begin
          if (!stop_op) begin
            case (op_q)
              OP_LD, OP_ST: begin
                emar_d  = 1'b1;
                iaddr_d = 1'b1;
              end
              OP_LN: begin
                emar_d = 1'b1;
                idr_d  = dst_oh;
              end
              OP_CP: begin
                idr_d = dst_oh;
                edr_d = src_oh;
              end
              OP_JZ, OP_JB, OP_JMP: begin
                emar_d = jump_taken;
                epc_d  = jump_taken;
              end
              OP_PUSH: begin
                edr_d   = sp_oh;
                iaddr_d = 1'b1;
              end
              OP_POP: sp_inc_d = 1'b1;
              default: begin
                if (is_alu) begin
                  ialu_d = 1'b1;
                  if (dst_q == 3'd0) emar_d = 1'b1;
                  else               edr_d  = dst_oh;
                end
              end
            endcase
          end
        end
        3'd4: begin
          case (op_q)
            OP_LD: begin
              eram_d = 1'b1;
              idr_d  = dst_oh;
            end
            OP_ST, OP_PUSH: begin
              iram_d = 1'b1;
              edr_d  = dst_oh;
            end
            OP_POP: begin
              edr_d   = sp_oh;
              iaddr_d = 1'b1;
            end
            default: ;
          endcase
        end
        3'd5: begin
          if (is_alu) begin
            ealu_d = 1'b1;
            idr_d  = NREG'(1);
          end else if (op_q == OP_PUSH) begin
            sp_dec_d = 1'b1;
          end else if (op_q == OP_POP) begin
            eram_d = 1'b1;
            idr_d  = dst_oh;
          end
        end
        3'd7: ipc_d = !(is_jump && taken_q);
        default: ;
      endcase
    end
  end

  assign beat_o    = beat_q;
  assign idr_o     = idr_q;
  assign edr_o     = edr_q;
  assign iir_o     = iir_q;
  assign eir_o     = eir_q;
  assign imar_o    = imar_q;
  assign emar_o    = emar_q;
  assign iaddr_o   = iaddr_q;
  assign iram_o    = iram_q;
  assign eram_o    = eram_q;
  assign ialu_o    = ialu_q;
  assign ealu_o    = ealu_q;
  assign ipc_o     = ipc_q;
  assign epc_o     = epc_q;
  assign sp_inc_o  = sp_inc_q;
  assign sp_dec_o  = sp_dec_q;
  assign halt_o    = halt_q;
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: randomized instruction stream against a per-beat schedule model of ctrl_seq,
// plus directed reset, stall, jump, stack, halt and fault scenarios.
module tb_ctrl_seq;
  localparam int DW     = 16;
  localparam int NREG   = 4;
  localparam int SP_IDX = 3;

  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic            run     = 1'b0;
  logic [DW-1:0]   cmd     = '0;
  logic [DW-1:0]   acc     = '0;
  logic            mem_rdy = 1'b1;
  logic [2:0]      beat;
  logic [NREG-1:0] idr, edr;
  logic iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu, ipc, epc, sp_inc, sp_dec, halt, illegal;

  always #5 clk = ~clk;

  ctrl_seq #(.DW(DW), .NREG(NREG), .SP_IDX(SP_IDX)) dut (
    .clk(clk), .reset(reset), .run_i(run), .cmd_i(cmd), .acc_i(acc), .mem_rdy_i(mem_rdy),
    .beat_o(beat), .idr_o(idr), .edr_o(edr), .iir_o(iir), .eir_o(eir), .imar_o(imar),
    .emar_o(emar), .iaddr_o(iaddr), .iram_o(iram), .eram_o(eram), .ialu_o(ialu),
    .ealu_o(ealu), .ipc_o(ipc), .epc_o(epc), .sp_inc_o(sp_inc), .sp_dec_o(sp_dec),
    .halt_o(halt), .illegal_o(illegal)
  );

  typedef logic [22:0] vec_t;
  localparam vec_t M_ILL   = vec_t'(1) << 0;
  localparam vec_t M_HALT  = vec_t'(1) << 1;
  localparam vec_t M_SPDEC = vec_t'(1) << 2;
  localparam vec_t M_SPINC = vec_t'(1) << 3;
  localparam vec_t M_EPC   = vec_t'(1) << 4;
  localparam vec_t M_IPC   = vec_t'(1) << 5;
  localparam vec_t M_EALU  = vec_t'(1) << 6;
  localparam vec_t M_IALU  = vec_t'(1) << 7;
  localparam vec_t M_ERAM  = vec_t'(1) << 8;
  localparam vec_t M_IRAM  = vec_t'(1) << 9;
  localparam vec_t M_IADDR = vec_t'(1) << 10;
  localparam vec_t M_EMAR  = vec_t'(1) << 11;
  localparam vec_t M_IMAR  = vec_t'(1) << 12;
  localparam vec_t M_EIR   = vec_t'(1) << 13;
  localparam vec_t M_IIR   = vec_t'(1) << 14;

  vec_t act;
  assign act = {idr, edr, iir, eir, imar, emar, iaddr, iram, eram, ialu, ealu,
                ipc, epc, sp_inc, sp_dec, halt, illegal};

  int   total = 0;
  int   bad   = 0;
  vec_t exp_s [8];
  bit   exp_stop;

  function automatic vec_t ridr(input int r);
    return (r >= 1 && r <= NREG) ? (vec_t'(1) << (19 + r - 1)) : '0;
  endfunction

  function automatic vec_t redr(input int r);
    return (r >= 1 && r <= NREG) ? (vec_t'(1) << (15 + r - 1)) : '0;
  endfunction

  // Reference: the expected enable set for each beat of one instruction.
  task automatic model_instr(input logic [DW-1:0] c, input logic [DW-1:0] a);
    int op, d, s;
    bit alu, need_reg, badf, taken;
    op = int'(c[15:11]);
    d  = int'(c[10:8]);
    s  = int'(c[2:0]);
    alu      = (op inside {5, 6, 7, 11, 12, 13, 14, 15});
    need_reg = (op inside {1, 2, 3, 4, 16, 17});
    badf = (op > 18) || (need_reg && (d < 1 || d > NREG)) ||
           (op == 3 && (s < 1 || s > NREG || s == d)) || (alu && d > NREG);
    taken = (op == 10) || (op == 8 && a == 0) || (op == 9 && a[15]);
    for (int i = 0; i < 8; i++) exp_s[i] = '0;
    exp_s[1] = M_IIR;
    exp_s[2] = M_EIR | M_IMAR;
    exp_s[7] = M_IPC;
    exp_stop = 1'b0;
    if (badf) begin
      exp_s[3] = M_HALT | M_ILL;
      exp_stop = 1'b1;
    end else if (op == 18) begin
      exp_s[3] = M_HALT;
      exp_stop = 1'b1;
    end else if (alu) begin
      exp_s[3] = M_IALU | ((d == 0) ? M_EMAR : redr(d));
      exp_s[5] = M_EALU | ridr(1);
    end else begin
      case (op)
        1: begin exp_s[3] = M_EMAR | M_IADDR; exp_s[4] = M_ERAM | ridr(d); end
        2: exp_s[3] = M_EMAR | ridr(d);
        3: exp_s[3] = ridr(d) | redr(s);
        4: begin exp_s[3] = M_EMAR | M_IADDR; exp_s[4] = M_IRAM | redr(d); end
        8, 9, 10: if (taken) begin exp_s[3] = M_EMAR | M_EPC; exp_s[7] = '0; end
        16: begin
          exp_s[3] = redr(SP_IDX) | M_IADDR;
          exp_s[4] = M_IRAM | redr(d);
          exp_s[5] = M_SPDEC;
        end
        17: begin
          exp_s[3] = M_SPINC;
          exp_s[4] = redr(SP_IDX) | M_IADDR;
          exp_s[5] = M_ERAM | ridr(d);
        end
        default: ;
      endcase
    end
  endtask

  // Runs one instruction from T0; stall_n < 0 picks a random wait count per RAM beat.
  task automatic exec(input logic [DW-1:0] c, input logic [DW-1:0] a, input int stall_n);
    int n, drv;
    model_instr(c, a);
    $display("instr cmd=%h acc=%h", c, a);
    cmd = c; acc = a; run = 1'b1; mem_rdy = 1'b1;
    for (int b = 1; b < 8; b++) begin
      @(negedge clk);
      total++;
      if (beat !== 3'(b) || act !== exp_s[b]) begin
        bad++;
        $display("FAIL exec_beat cmd=%h acc=%h beat got=%0d want=%0d outs got=%h want=%h",
                 c, a, beat, b, act, exp_s[b]);
      end
      drv = $countones(edr) + int'(eir) + int'(emar) + int'(eram) + int'(ealu);
      total++;
      if (drv > 1 || (idr & edr) != '0) begin
        bad++;
        $display("FAIL bus_excl cmd=%h beat=%0d drivers got=%0d want<=1 idr&edr got=%h want=0",
                 c, beat, drv, idr & edr);
      end
      if ((exp_s[b] & (M_IRAM | M_ERAM)) != '0) begin
        n = (stall_n < 0) ? int'($urandom_range(0, 3)) : stall_n;
        mem_rdy = 1'b0;
        repeat (n) begin
          @(negedge clk);
          total++;
          if (beat !== 3'(b) || act !== exp_s[b]) begin
            bad++;
            $display("FAIL stall_hold cmd=%h beat got=%0d want=%0d outs got=%h want=%h",
                     c, beat, b, act, exp_s[b]);
          end
        end
        mem_rdy = 1'b1;
      end
      if (exp_stop && b == 3) begin
        repeat (3) begin
          @(negedge clk);
          total++;
          if (beat !== 3'd3 || act !== exp_s[3]) begin
            bad++;
            $display("FAIL halt_freeze cmd=%h beat got=%0d want=3 outs got=%h want=%h",
                     c, beat, act, exp_s[3]);
          end
        end
        return;
      end
    end
    @(negedge clk);
    total++;
    if (beat !== 3'd0 || act !== '0) begin
      bad++;
      $display("FAIL wrap_t0 cmd=%h beat got=%0d want=0 outs got=%h want=0", c, beat, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; run = 1'b0; mem_rdy = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    cmd = 16'h3200; run = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    total++;
    if (beat !== 3'd0 || act !== '0) begin
      bad++;
      $display("FAIL reset_state beat got=%0d want=0 outs got=%h want=0", beat, act);
    end
    run = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (beat !== 3'd0 || act !== '0) begin
        bad++;
        $display("FAIL idle_run0 beat got=%0d want=0 outs got=%h want=0", beat, act);
      end
    end
  endtask

  task automatic test_nop();
    exec(16'h0000, 16'h1234, 0);
    exec(16'h0000, 16'h0000, 0);
  endtask

  task automatic test_add();
    exec(16'h3200, 16'($urandom), 0);
  endtask

  task automatic test_jz();
    exec(16'h4000, 16'h0000, 0);
    exec(16'h4000, 16'h0005, 0);
    exec(16'h4800, 16'h8001, 0);
    exec(16'h4800, 16'h7fff, 0);
    exec(16'h5000, 16'h1111, 0);
  endtask

  task automatic test_ld_stall();
    exec(16'h0900, 16'($urandom), 3);
  endtask

  task automatic test_push_pop();
    exec(16'h8100, 16'($urandom), 0);
    exec(16'h8C00, 16'($urandom), 2);
  endtask

  task automatic test_back_to_back();
    int op, d, s, k;
    logic [DW-1:0] c, a;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 17));
      if (op inside {5, 6, 7, 11, 12, 13, 14, 15}) d = int'($urandom_range(0, NREG));
      else                                        d = int'($urandom_range(1, NREG));
      if (op == 3) begin
        s = int'($urandom_range(1, NREG));
        if (s == d) s = (d % NREG) + 1;
      end else begin
        s = int'($urandom_range(0, 7));
      end
      c = {op[4:0], d[2:0], 5'($urandom), s[2:0]};
      a = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      exec(c, a, -1);
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        k = int'($urandom_range(1, 3));
        repeat (k) begin
          @(negedge clk);
          total++;
          if (beat !== 3'd0 || act !== '0) begin
            bad++;
            $display("FAIL idle_gap beat got=%0d want=0 outs got=%h want=0", beat, act);
          end
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] list [7];
    list = '{16'hA000, 16'hF800, 16'h0800, 16'h0D00, 16'h1900, 16'h3700, 16'h8000};
    for (int i = 0; i < 7; i++) begin
      exec(list[i], 16'($urandom), 0);
      do_reset();
    end
  endtask

  task automatic test_halt();
    exec(16'h9000, 16'h0000, 0);
    do_reset();
  endtask

  task automatic test_async_reset();
    int k;
    cmd = 16'h0900; acc = '0; run = 1'b1; mem_rdy = 1'b0;
    k = 0;
    while (beat !== 3'd4 && k < 12) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (beat !== 3'd4 || eram !== 1'b1) begin
      bad++;
      $display("FAIL areset_setup beat got=%0d want=4 eram got=%b want=1", beat, eram);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (beat !== 3'd0 || act !== '0) begin
      bad++;
      $display("FAIL areset_clear beat got=%0d want=0 outs got=%h want=0", beat, act);
    end
    run = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    exec(16'h0000, 16'h0000, 0);
  endtask

  initial begin
    test_reset();
    test_nop();
    test_add();
    test_jz();
    test_ld_stall();
    test_push_pop();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
